serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the single-bit FA stage; the FA is the combinational core, this block is the sequential stage around it.
- Shifts operands LSB-first into FA, registers Cout as next-cycle Cin, shifts sum bits into result register.
- Used in the lab datapath as the area-minimal alternative to the ripple-carry adder; one bit per clock.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request new addition; sampled only when not busy.
- a  input  N  operand A, captured on accepted start.
- b  input  N  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: sum/cout valid.
- sum  output  N  result; holds last completed value until next accepted start.
- cout  output  1  final carry-out; holds as sum.

Behaviour:
- Single clock, clk; reset asynchronous, active-low, on rst_n.
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers, carry register and bit counter = 0.
- States: IDLE, ADD, DONE.
- IDLE: start=1 at an edge -> load A_reg=a, B_reg=b, carry=cin, count=0; go ADD. start=0 -> stay.
- ADD (busy=1): each edge: FA inputs A_reg[0], B_reg[0], carry; carry <= FA Cout; A_reg/B_reg shift right 1 (MSB fill 0); sum register shifts right with FA S entering MSB; count++. On edge where count reaches N-1 (N-th processed bit): go DONE, cout <= FA Cout.
- DONE (busy=0, done=1 for exactly this cycle): next edge -> IDLE, or if start=1 -> load and go ADD directly (back-to-back accepted).
- Latency: start accepted at edge t0 -> done high in cycle after edge tN (N+1 edges after start edge). Throughput: one result per N+1 cycles with back-to-back start.
- start while busy=1: ignored, no effect on operands or result.
- Input a/b/cin changes after capture: no effect.
- sum visible during ADD is partial (shifting); valid only when done=1 or later in IDLE.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(N+1); no saturation.
- rst_n asserted mid-operation: immediately abort to reset values; no done pulse; result discarded.
- Counter width ceil(log2(N)); wraps never observed (terminates at N-1).

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined: extra output port ovf (1 bit), signed two's-complement overflow = carry into MSB XOR carry out of MSB; captured on N-th bit edge, reset 0, held with sum/cout, cleared on accepted start.
- Not defined: port ovf absent; no extra logic; all other behaviour identical.

Test Plan:
- N=8, a=0x35, b=0x4A, cin=0, start 1 cycle -> done pulse 9 edges after start edge, sum=0x7F, cout=0, busy high exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with SERIAL_ADDER_OVF_EN ovf=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1 (when enabled); a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Start 0x10+0x20, pulse start again with a=0xAA,b=0x55 at 3rd busy cycle -> ignored; result 0x30, cout=0.
- start held high across DONE -> second op (a=0x01,b=0x02) accepted in DONE cycle, busy reasserts next cycle, second done gives sum=0x03; first result 0x30 seen on first done.
- Assert rst_n=0 at 4th ADD cycle, release, no start -> no done pulse, sum=0, cout=0, busy=0; subsequent 0x35+0x4A completes correctly to 0x7F.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder bit per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_sum;
  logic          r_carry;
  logic          r_cout;
  logic [CW-1:0] r_cnt;

  logic w_s;
  logic w_co;
  logic w_add;
  logic w_ld;
  logic w_last;

  // single-bit full adder on the current LSBs
  assign w_s  = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_co = (r_a[0] & r_b[0])
              | (r_a[0] & r_carry)
              | (r_b[0] & r_carry);

  assign w_add  = (r_state == S_ADD);
  assign w_ld   = !w_add && start;
  assign w_last = (r_cnt == CW'(N - 1));

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      unique case (1'b1)
        w_ld: begin
          r_state <= S_ADD;
          r_a     <= a;
          r_b     <= b;
          r_carry <= cin;
          r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
          r_ovf   <= 1'b0;
`endif
        end
        w_add: begin
          r_carry <= w_co;
          r_a     <= {1'b0, r_a[N-1:1]};
          r_b     <= {1'b0, r_b[N-1:1]};
          r_sum   <= {w_s, r_sum[N-1:1]};
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_cout  <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
            // carry into MSB differs from carry out of MSB
            r_ovf   <= r_carry ^ w_co;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = w_add;
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: reference is plain integer addition.
// Build with SERIAL_ADDER_OVF_EN to also check ovf.
module tb_serial_adder;

  localparam int N = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a     = '0;
  logic [N-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   run    = 0;
  int   ndone  = 0;
  logic pdone  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] x,
                                 input logic [N-1:0] y,
                                 input logic c);
    exp_t e;
    int   t, sx, sy, ss;
    t    = int'(x) + int'(y) + int'(c);
    e.s  = N'(t % (1 << N));
    e.co = (t >= (1 << N));
    sx   = x[N-1] ? int'(x) - (1 << N) : int'(x);
    sy   = y[N-1] ? int'(y) - (1 << N) : int'(y);
    ss   = sx + sy + int'(c);
    e.ov = (ss > (1 << (N-1)) - 1) || (ss < -(1 << (N-1)));
    return e;
  endfunction

  // An issued request is accepted at an edge where start is high and the
  // block is not busy; the expected response is queued at that point.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && start && !busy) begin
      exp_q.push_back(model(a, b, cin));
      acc_q.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   t0;
    if (!rst_n) begin
      run   = 0;
      pdone = 1'b0;
    end else begin
      if (done) begin
        ndone++;
        chk("done_width", 64'(pdone), 64'd0);
        chk("busy_in_done", 64'(busy), 64'd0);
        chk("busy_cycles", 64'(run), 64'(N));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no result");
        end else begin
          e  = exp_q.pop_front();
          t0 = acc_q.pop_front();
          chk("sum", 64'(sum), 64'(e.s));
          chk("cout", 64'(cout), 64'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf", 64'(ovf), 64'(e.ov));
`endif
          chk("latency", 64'(cyc - t0), 64'(N + 1));
        end
      end
      if (busy) run++;
      else run = 0;
      pdone = done;
    end
  end

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic c);
    int k = 0;
    @(posedge clk); #1;
    while (busy && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got busy=1, expected 0");
    end
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(posedge clk); #1;
    while ((busy || done || exp_q.size() != 0) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy || done || exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got pending=%0d, expected 0",
               exp_q.size());
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_sum"}, 64'(sum), 64'd0);
    chk({nm, "_cout"}, 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk({nm, "_ovf"}, 64'(ovf), 64'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int nd;
    @(posedge clk); #1;
    chk_zero("reset");
    rst_n = 1'b1;

    issue(8'h35, 8'h4A, 1'b0);
    wait_idle();
    chk("hold_sum", 64'(sum), 64'h7F);
    chk("hold_cout", 64'(cout), 64'd0);

    issue(8'hFF, 8'h01, 1'b0);
    issue(8'h7F, 8'h01, 1'b0);
    issue(8'hFF, 8'h00, 1'b1);
    wait_idle();

    // start pulsed during the 3rd busy cycle must be ignored
    issue(8'h10, 8'h20, 1'b0);
    @(posedge clk); #1;
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    chk("ignored_sum", 64'(sum), 64'h30);

    // start held high through DONE: second op accepted in the DONE cycle
    a     = 8'h10;
    b     = 8'h20;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    a = 8'h01;
    b = 8'h02;
    k = 0;
    while (!done && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_first_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_idle();
    chk("b2b_sum", 64'(sum), 64'h03);

    // reset in the 4th ADD cycle aborts with no done pulse
    issue(8'h35, 8'h4A, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    nd    = ndone;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk_zero("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(ndone), 64'(nd));
    chk_zero("after_abort");
    issue(8'h35, 8'h4A, 1'b0);
    wait_idle();
    chk("post_abort_sum", 64'(sum), 64'h7F);

    repeat (150) begin
      issue(N'($urandom), N'($urandom), 1'($urandom));
      if ($urandom_range(3) == 0)
        repeat ($urandom_range(5)) @(posedge clk);
    end
    wait_idle();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
